// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 hex keypad scanner: FSM encoding, key map
// and small row/column helpers.
package keypad_scanner_pkg;

  typedef logic [1:0] state_t;

  localparam state_t SCAN     = 2'd0;
  localparam state_t DEBOUNCE = 2'd1;
  localparam state_t HELD     = 2'd2;
  localparam state_t RELEASE  = 2'd3;

  localparam logic [3:0] ROW_RESET = 4'b1110;
  localparam logic [3:0] COL_IDLE  = 4'b1111;

  // Indexed [row][col]; index 0 is the LSB of row_n / col_n.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] rotate_row(input logic [3:0] row_n);
    return {row_n[2:0], row_n[3]};
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] row_n);
    case (row_n)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] lowest_low_col(input logic [3:0] col_n);
    if (!col_n[0])      return 2'd0;
    else if (!col_n[1]) return 2'd1;
    else if (!col_n[2]) return 2'd2;
    else                return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Generic two-flop synchronizer for asynchronous board inputs, with a
// configurable reset value so idle-high lines do not glitch out of reset.
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Row-strobing 4x4 hex keypad scanner with press/release debounce; shifts each
// accepted digit into a 16-bit value that feeds the 7-segment display driver.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [15:0] value,
  output logic        value_we
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

  logic [3:0]    col_s;
  state_t        state_q, state_d;
  logic [3:0]    row_n_q, row_n_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] deb_q, deb_d;
  logic [1:0]    row_sel_q, row_sel_d;
  logic [1:0]    col_sel_q, col_sel_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_held_q, key_held_d;
  logic [15:0]   value_q, value_d;
  logic          col_bit;
  logic [3:0]    map_code;

  sync2 #(.WIDTH(4), .RESET_VAL(COL_IDLE)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_s)
  );

  // Once a key is latched only its own column is watched; other keys are ignored.
  assign col_bit  = col_s[col_sel_q];
  assign map_code = KEY_MAP[row_sel_q][col_sel_q];

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    row_n_d     = row_n_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    row_sel_d   = row_sel_q;
    col_sel_d   = col_sel_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    value_d     = value_q;

    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (col_s != COL_IDLE) begin
            row_sel_d = row_index(row_n_q);
            col_sel_d = lowest_low_col(col_s);
            deb_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            row_n_d = rotate_row(row_n_q);
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_bit) begin
          deb_d   = '0;
          row_n_d = rotate_row(row_n_q);
          state_d = SCAN;
        end else if (deb_q == DEB_LAST) begin
          key_valid_d = 1'b1;
          key_code_d  = map_code;
          value_d     = {value_q[11:0], map_code};
          deb_d       = '0;
          state_d     = HELD;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      HELD: begin
        if (col_bit) begin
          deb_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!col_bit) begin
          deb_d   = '0;
          state_d = HELD;
        end else if (deb_q == DEB_LAST) begin
          deb_d   = '0;
          row_n_d = rotate_row(row_n_q);
          state_d = SCAN;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase

    key_held_d = (state_d == HELD) || (state_d == RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      row_n_q     <= ROW_RESET;
      dwell_q     <= '0;
      deb_q       <= '0;
      row_sel_q   <= '0;
      col_sel_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
      value_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_n_q     <= row_n_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      row_sel_q   <= row_sel_d;
      col_sel_q   <= col_sel_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      value_q     <= value_d;
    end
  end

  assign row_n     = row_n_q;
  assign key_valid = key_valid_q;
  assign value_we  = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign value     = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural 4x4 key matrix drives col_n
// from row_n; table-driven single presses plus hand-written corner sequences.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] value;
  logic        value_we;

  logic [3:0][3:0] pressed;  // pressed[row][col]

  int n_checks = 0;
  int n_fail   = 0;
  int kv_cnt   = 0;
  int we_cnt   = 0;

  typedef struct {
    logic [1:0]  row;
    logic [1:0]  col;
    logic [3:0]  code;
    logic [15:0] value;
  } vec_t;

  vec_t vecs[11];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .value     (value),
    .value_we  (value_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Passive matrix: a pressed key pulls its column low only while its row is driven.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid) kv_cnt++;
    if (value_we) we_cnt++;
    if (key_valid || value_we) check("valid_we_align", 32'(value_we), 32'(key_valid));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_release(input string name, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (key_held && n < budget);
    check(name, 32'(key_held), 32'd0);
  endtask

  initial begin
    logic [3:0] prev_row;
    int         run;
    int         kv0;
    int         we0;
    int         n_rel;
    logic [3:0] next_row;
    bit         left;

    vecs[0]  = '{2'd1, 2'd2, 4'h6, 16'h0006};
    vecs[1]  = '{2'd0, 2'd0, 4'h1, 16'h0061};
    vecs[2]  = '{2'd0, 2'd1, 4'h2, 16'h0612};
    vecs[3]  = '{2'd0, 2'd2, 4'h3, 16'h6123};
    vecs[4]  = '{2'd0, 2'd3, 4'hA, 16'h123A};
    vecs[5]  = '{2'd1, 2'd3, 4'hB, 16'h23AB};
    vecs[6]  = '{2'd3, 2'd0, 4'hE, 16'h3ABE};
    vecs[7]  = '{2'd3, 2'd1, 4'h0, 16'hABE0};
    vecs[8]  = '{2'd3, 2'd3, 4'hD, 16'hBE0D};
    vecs[9]  = '{2'd2, 2'd2, 4'h9, 16'hE0D9};
    vecs[10] = '{2'd2, 2'd0, 4'h7, 16'h0D97};

    pressed = '0;
    rst     = 1'b1;
    tick(2);
    rst = 1'b0;

    // Reset values, then idle scanning with rotation every 4 cycles.
    check("rst_row_n",     32'(row_n),     32'h000E);
    check("rst_value",     32'(value),     32'h0000);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_value_we",  32'(value_we),  32'd0);
    check("rst_key_code",  32'(key_code),  32'd0);
    check("rst_key_held",  32'(key_held),  32'd0);
    prev_row = row_n;
    run      = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (row_n != prev_row) begin
        check("idle_rotate", 32'(row_n), 32'({prev_row[2:0], prev_row[3]}));
        check("idle_dwell",  32'(run),   32'd4);
        prev_row = row_n;
        run      = 1;
      end else begin
        run++;
      end
    end
    tick(160);
    check("idle_no_valid", 32'(kv_cnt), 32'd0);
    check("idle_no_we",    32'(we_cnt), 32'd0);
    check("idle_value",    32'(value),  32'h0000);

    // Single presses; the first one also checks release-debounce timing:
    // 2 sync cycles + 1 HELD detect + 8 stable release samples.
    for (int v = 0; v < 11; v++) begin
      kv0 = kv_cnt;
      if (v == 1) we0 = we_cnt;
      pressed[vecs[v].row][vecs[v].col] = 1'b1;
      wait_pulse("press_timeout", 100);
      check("press_code",  32'(key_code), 32'(vecs[v].code));
      check("press_value", 32'(value),    32'(vecs[v].value));
      check("press_held",  32'(key_held), 32'd1);
      tick(60);
      check("no_repeat", 32'(kv_cnt - kv0), 32'd1);
      pressed[vecs[v].row][vecs[v].col] = 1'b0;
      wait_release("release_timeout", 60, n_rel);
      if (v == 0) check("release_latency", 32'(n_rel), 32'd11);
      if (v == 5) check("we_count_1_to_B", 32'(we_cnt - we0), 32'd5);
      tick(5);
      check("one_pulse_per_press", 32'(kv_cnt - kv0), 32'd1);
    end

    // Two keys in one row: lowest column wins; another row pressed while held is ignored.
    kv0 = kv_cnt;
    pressed[0][0] = 1'b1;
    pressed[0][3] = 1'b1;
    wait_pulse("multi_timeout", 100);
    check("multi_code",  32'(key_code), 32'h1);
    check("multi_value", 32'(value),    32'hD971);
    tick(5);
    pressed[2][1] = 1'b1;
    tick(40);
    pressed[2][1] = 1'b0;
    tick(5);
    check("held_ignore_other", 32'(kv_cnt - kv0), 32'd1);
    pressed[0][0] = 1'b0;
    pressed[0][3] = 1'b0;
    wait_release("multi_release", 60, n_rel);
    tick(30);
    check("multi_one_pulse", 32'(kv_cnt - kv0), 32'd1);

    // Bounce on r0/c1 aligned to the start of row 0's dwell: decision at dwell end
    // sees the first low burst, DEBOUNCE sees the high glitch and moves on to row 1.
    left = 1'b0;
    for (int i = 0; i < 60 && !left; i++) begin
      prev_row = row_n;
      @(negedge clk);
      if (row_n == 4'b1110 && prev_row != 4'b1110) left = 1'b1;
    end
    check("bounce_align", 32'(left), 32'd1);
    kv0      = kv_cnt;
    run      = 0;
    left     = 1'b0;
    next_row = 4'b1110;
    for (int i = 0; i < 12; i++) begin
      if (!left && row_n == 4'b1110) run++;
      else if (!left) begin
        left     = 1'b1;
        next_row = row_n;
      end
      pressed[0][1] = (i <= 2) || (i >= 4 && i <= 6);
      @(negedge clk);
    end
    pressed[0][1] = 1'b0;
    tick(40);
    check("bounce_frozen_run", 32'(run),          32'd6);
    check("bounce_next_row",   32'(next_row),     32'hD);
    check("bounce_no_valid",   32'(kv_cnt - kv0), 32'd0);

    // Reset while HELD: everything clears, the still-held key is taken again as new.
    pressed[1][0] = 1'b1;
    wait_pulse("held_rst_press_timeout", 100);
    check("held_rst_code",  32'(key_code), 32'h4);
    check("held_rst_value", 32'(value),    32'h9714);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("after_rst_value",    32'(value),    32'h0000);
    check("after_rst_held",     32'(key_held), 32'd0);
    check("after_rst_row_n",    32'(row_n),    32'hE);
    check("after_rst_key_code", 32'(key_code), 32'h0);
    kv0 = kv_cnt;
    wait_pulse("repress_timeout", 100);
    check("repress_code",  32'(key_code), 32'h4);
    check("repress_value", 32'(value),    32'h0004);
    tick(20);
    pressed[1][0] = 1'b0;
    wait_release("repress_release", 60, n_rel);
    tick(30);
    check("repress_one_pulse", 32'(kv_cnt - kv0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
